// File: rtl/fdc_multi.sv
// Multi-drive, two-sided floppy disk controller, FD1771-compatible register set,
// backed by an external synchronous single-port sector RAM.
module fdc_multi #(
  parameter int DRIVES       = 4,
  parameter int SIDES        = 2,
  parameter int TRACKS       = 40,
  parameter int SECTORS      = 16,
  parameter int SECTOR_BYTES = 128,
  parameter int MEM_AW       = 20,
  localparam int DRW         = (DRIVES > 1) ? $clog2(DRIVES) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WE,
  input  logic              RE,
  input  logic [1:0]        A,
  inout  wire  [7:0]        DAL,
  input  logic [DRW-1:0]    DRIVE_SEL,
  input  logic              SIDE_SEL,
  input  logic [DRIVES-1:0] WPROT,
  output logic              DRQ,
  output logic              INTRQ,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic [7:0]        MEM_DOUT,
  output logic              MEM_WE,
  input  logic [7:0]        MEM_DIN
);

  typedef enum logic [2:0] {IDLE, FETCH, RDWAIT, WRWAIT, COMMIT, NEXT} state_t;

  localparam logic [7:0] TRK_LIM  = 8'(TRACKS);
  localparam logic [7:0] TRK_TOP  = 8'(TRACKS - 1);
  localparam logic [7:0] SEC_LIM  = 8'(SECTORS);
  localparam logic [8:0] OFF_LAST = 9'(SECTOR_BYTES - 1);
  localparam logic [3:0] CMD_FI   = 4'b1101;

  state_t         state;
  logic           re_p1, we_p1;
  logic [3:0]     cmd_p1;
  logic           cmd_vld_p1;
  logic [DRW-1:0] drv_p1, drv;
  logic           side_p1, side;
  logic [7:0]     track, sector, data;
  logic [8:0]     offset;
  logic           multi, wr_mode;
  logic           not_ready, wp_err, rnf, busy, drq, intrq;
  logic [7:0]     din, status, rd_val;
  logic           re_acc, we_acc, rec_ok;

  function automatic logic [MEM_AW-1:0] calc_addr(input logic [DRW-1:0] d, input logic s,
                                                  input logic [7:0] t, input logic [7:0] sc,
                                                  input logic [8:0] o);
    logic [31:0] lin;
    lin = ((32'(d) * 32'(SIDES) + 32'(s)) * 32'(TRACKS) + 32'(t)) * 32'(SECTORS)
          + 32'(sc) - 32'd1;
    return MEM_AW'(lin * 32'(SECTOR_BYTES) + 32'(o));
  endfunction

  // Bus is inverted in both directions; one action per strobe falling edge.
  assign din    = ~DAL;
  assign re_acc = !RE && re_p1;
  assign we_acc = !WE && we_p1;
  assign rec_ok = (track < TRK_LIM) && (sector != 8'd0) && (sector <= SEC_LIM);
  assign status = {not_ready, wp_err, 1'b0, rnf, 2'b00, drq, busy};
  assign DRQ    = drq;
  assign INTRQ  = intrq;

  always_comb begin
    rd_val = status;
    unique case (A)
      2'd1:    rd_val = track;
      2'd2:    rd_val = sector;
      2'd3:    rd_val = data;
      default: rd_val = status;
    endcase
  end

  assign DAL = RE ? 8'hzz : ~rd_val;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      re_p1      <= 1'b1;
      we_p1      <= 1'b1;
      cmd_p1     <= 4'd0;
      cmd_vld_p1 <= 1'b0;
      drv_p1     <= '0;
      side_p1    <= 1'b0;
      drv        <= '0;
      side       <= 1'b0;
      track      <= 8'd0;
      sector     <= 8'd0;
      data       <= 8'd0;
      offset     <= 9'd0;
      multi      <= 1'b0;
      wr_mode    <= 1'b0;
      not_ready  <= 1'b1;
      wp_err     <= 1'b0;
      rnf        <= 1'b0;
      busy       <= 1'b0;
      drq        <= 1'b0;
      intrq      <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_DOUT   <= 8'd0;
      MEM_WE     <= 1'b0;
    end else begin
      re_p1      <= RE;
      we_p1      <= WE;
      MEM_WE     <= 1'b0;
      cmd_vld_p1 <= 1'b0;

      // p0 -> p1: host register access; commands are staged for one cycle
      if (we_acc) begin
        unique case (A)
          2'd0: begin
            cmd_p1     <= din[7:4];
            cmd_vld_p1 <= 1'b1;
            drv_p1     <= DRIVE_SEL;
            side_p1    <= (SIDES > 1) ? SIDE_SEL : 1'b0;
          end
          2'd1:    if (!busy) track <= din;
          2'd2:    if (!busy) sector <= din;
          default: if (!busy) data <= din;
        endcase
      end
      if (re_acc && A == 2'd0) intrq <= 1'b0;

      unique case (state)
        FETCH: state <= RDWAIT;
        RDWAIT: begin
          // RAM data is valid the cycle after FETCH; drq low marks an unloaded byte
          if (!drq) begin
            data <= MEM_DIN;
            drq  <= 1'b1;
          end else if (re_acc && A == 2'd3) begin
            drq    <= 1'b0;
            offset <= offset + 9'd1;
            if (offset == OFF_LAST) begin
              state <= NEXT;
            end else begin
              MEM_ADDR <= calc_addr(drv, side, track, sector, offset + 9'd1);
              state    <= FETCH;
            end
          end
        end
        WRWAIT: begin
          if (drq && we_acc && A == 2'd3) begin
            data  <= din;
            drq   <= 1'b0;
            state <= COMMIT;
          end
        end
        COMMIT: begin
          MEM_WE   <= 1'b1;
          MEM_DOUT <= data;
          MEM_ADDR <= calc_addr(drv, side, track, sector, offset);
          offset   <= offset + 9'd1;
          if (offset == OFF_LAST) begin
            state <= NEXT;
          end else begin
            drq   <= 1'b1;
            state <= WRWAIT;
          end
        end
        NEXT: begin
          if (!multi || sector == SEC_LIM) begin
            rnf   <= multi;
            busy  <= 1'b0;
            intrq <= 1'b1;
            state <= IDLE;
          end else begin
            sector <= sector + 8'd1;
            offset <= 9'd0;
            if (wr_mode) begin
              drq   <= 1'b1;
              state <= WRWAIT;
            end else begin
              MEM_ADDR <= calc_addr(drv, side, track, sector + 8'd1, 9'd0);
              state    <= FETCH;
            end
          end
        end
        default: ;
      endcase

      // p1: command execute, overrides any transfer activity in the same cycle
      if (cmd_vld_p1) begin
        if (busy) begin
          if (cmd_p1 == CMD_FI) begin
            state  <= IDLE;
            busy   <= 1'b0;
            drq    <= 1'b0;
            intrq  <= 1'b1;
            wp_err <= 1'b0;
            rnf    <= 1'b0;
            MEM_WE <= 1'b0;
          end
        end else begin
          wp_err <= 1'b0;
          rnf    <= 1'b0;
          intrq  <= 1'b0;
          case (cmd_p1)
            4'b0000: begin
              track     <= 8'd0;
              not_ready <= 1'b0;
              intrq     <= 1'b1;
            end
            4'b0001: begin
              track <= data;
              intrq <= 1'b1;
            end
            4'b0101: begin
              if (track < TRK_TOP) track <= track + 8'd1;
              intrq <= 1'b1;
            end
            4'b0111: begin
              if (track != 8'd0) track <= track - 8'd1;
              intrq <= 1'b1;
            end
            4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
              if (!rec_ok) begin
                rnf   <= 1'b1;
                intrq <= 1'b1;
              end else if (cmd_p1[1] && WPROT[drv_p1]) begin
                wp_err <= 1'b1;
                intrq  <= 1'b1;
              end else begin
                busy    <= 1'b1;
                multi   <= cmd_p1[0];
                wr_mode <= cmd_p1[1];
                drv     <= drv_p1;
                side    <= side_p1;
                offset  <= 9'd0;
                if (cmd_p1[1]) begin
                  drq   <= 1'b1;
                  state <= WRWAIT;
                end else begin
                  drq      <= 1'b0;
                  MEM_ADDR <= calc_addr(drv_p1, side_p1, track, sector, 9'd0);
                  state    <= FETCH;
                end
              end
            end
            CMD_FI: begin
              drq   <= 1'b0;
              intrq <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fdc_multi.sv
// Scoreboard bench for fdc_multi: a disk-image model predicts storage writes and
// host data reads; monitors compare whenever the DUT strobes memory or is read.
module tb_fdc_multi;
  localparam int DRIVES = 4, SIDES = 2, TRACKS = 40, SECTORS = 16, SB = 128, AW = 20;

  logic            CLK = 1'b0;
  logic            RESET, WE, RE;
  logic [1:0]      A;
  wire  [7:0]      DAL;
  logic [7:0]      bus_out;
  logic            bus_en;
  logic [1:0]      DRIVE_SEL;
  logic            SIDE_SEL;
  logic [3:0]      WPROT;
  logic            DRQ, INTRQ, MEM_WE;
  logic [AW-1:0]   MEM_ADDR;
  logic [7:0]      MEM_DOUT, MEM_DIN;

  assign DAL = bus_en ? ~bus_out : 8'hzz;

  fdc_multi #(.DRIVES(DRIVES), .SIDES(SIDES), .TRACKS(TRACKS), .SECTORS(SECTORS),
              .SECTOR_BYTES(SB), .MEM_AW(AW)) dut (
    .CLK(CLK), .RESET(RESET), .WE(WE), .RE(RE), .A(A), .DAL(DAL),
    .DRIVE_SEL(DRIVE_SEL), .SIDE_SEL(SIDE_SEL), .WPROT(WPROT),
    .DRQ(DRQ), .INTRQ(INTRQ), .MEM_ADDR(MEM_ADDR), .MEM_DOUT(MEM_DOUT),
    .MEM_WE(MEM_WE), .MEM_DIN(MEM_DIN));

  always #5 CLK = ~CLK;

  // Storage RAM attached to the DUT, and the expected disk image.
  logic [7:0] ram [0:(1<<AW)-1];
  logic [7:0] img [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (MEM_WE) ram[MEM_ADDR] <= MEM_DOUT;
    MEM_DIN <= ram[MEM_ADDR];
  end

  int checks = 0, errors = 0, wr_pulses = 0;
  typedef struct { int addr; logic [7:0] data; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  bit         rd_mon_en = 0;
  wr_t        we_e;
  logic       prev_re = 1'b1;
  logic [7:0] mon_v;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int ref_addr(input int d, input int s, input int t, input int sc, input int o);
    return (((d * SIDES + s) * TRACKS + t) * SECTORS + (sc - 1)) * SB + o;
  endfunction

  // Storage-write monitor
  always @(negedge CLK) begin
    if (MEM_WE === 1'b1) begin
      wr_pulses++;
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mem_we addr=%0d data=%0h required=no write", MEM_ADDR, MEM_DOUT);
      end else begin
        we_e = exp_wr.pop_front();
        chk("mem_we_addr", int'(MEM_ADDR), we_e.addr);
        chk("mem_we_data", int'(MEM_DOUT), int'(we_e.data));
      end
    end
  end

  // Host data-read monitor
  always @(negedge CLK) begin
    #1;
    if (rd_mon_en && !RE && prev_re && A == 2'd3) begin
      mon_v = ~DAL;
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_data_read actual=%0h required=no read", mon_v);
      end else begin
        chk("rd_data", int'(mon_v), int'(exp_rd.pop_front()));
      end
    end
    prev_re = RE;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [7:0] v);
    @(negedge CLK); A = a; bus_out = v; bus_en = 1'b1; WE = 1'b0;
    @(negedge CLK); WE = 1'b1; bus_en = 1'b0;
  endtask

  task automatic host_rd(input logic [1:0] a, output logic [7:0] v);
    @(negedge CLK); A = a; RE = 1'b0;
    #1 v = ~DAL;
    @(negedge CLK); RE = 1'b1;
  endtask

  task automatic wait_sig(input bit want_drq, output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if ((want_drq ? DRQ : INTRQ) === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout actual=0 required=1", want_drq ? "drq" : "intrq");
    end
  endtask

  task automatic start_cmd(input int d, input int s, input int t, input int sc, input logic [7:0] cmd);
    DRIVE_SEL = 2'(d); SIDE_SEL = 1'(s);
    host_wr(2'd1, 8'(t));
    host_wr(2'd2, 8'(sc));
    host_wr(2'd0, cmd);
  endtask

  task automatic xfer_read(input int d, input int s, input int t, input int sc, input bit m, input int n);
    int base; bit ok; logic [7:0] v;
    base = ref_addr(d, s, t, sc, 0);
    for (int i = 0; i < n; i++) exp_rd.push_back(img[base + i]);
    rd_mon_en = 1;
    start_cmd(d, s, t, sc, m ? 8'h90 : 8'h80);
    for (int i = 0; i < n; i++) begin
      wait_sig(1, ok);
      if (!ok) break;
      if (i == 0) begin
        chk("rd_first_addr", int'(MEM_ADDR), base);
        host_rd(2'd0, v);
        chk("rd_busy_status", int'(v), 8'h03);
      end
      if (i == n - 1) chk("rd_last_addr", int'(MEM_ADDR), base + n - 1);
      host_rd(2'd3, v);
    end
    wait_sig(0, ok);
    rd_mon_en = 0;
    chk("rd_all_consumed", exp_rd.size(), 0);
    exp_rd.delete();
  endtask

  task automatic xfer_write(input int d, input int s, input int t, input int sc, input int n_do, input bit incr);
    int base; bit ok; logic [7:0] b; wr_t e;
    base = ref_addr(d, s, t, sc, 0);
    start_cmd(d, s, t, sc, 8'hA0);
    for (int i = 0; i < n_do; i++) begin
      wait_sig(1, ok);
      if (!ok) break;
      b = incr ? 8'(i) : 8'($urandom);
      e.addr = base + i; e.data = b;
      exp_wr.push_back(e);
      img[base + i] = b;
      host_wr(2'd3, b);
    end
    if (n_do == SB) wait_sig(0, ok);
  endtask

  initial begin
    logic [7:0] v;
    int p, t, e;
    bit stepin;
    RESET = 1; WE = 1; RE = 1; A = 0; bus_en = 0; bus_out = 0;
    DRIVE_SEL = 0; SIDE_SEL = 0; WPROT = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 8'($urandom);
      img[i] = ram[i];
    end
    cycles(3);
    RESET = 0;
    cycles(1);
    chk("reset_drq", DRQ, 0);
    chk("reset_intrq", INTRQ, 0);
    chk("reset_mem_we", MEM_WE, 0);
    chk("reset_mem_addr", int'(MEM_ADDR), 0);
    host_rd(2'd0, v);  chk("reset_status", v, 8'h80);

    host_wr(2'd0, 8'h00);
    cycles(2);
    chk("restore_intrq", INTRQ, 1);
    host_rd(2'd0, v);  chk("restore_status", v, 8'h00);
    chk("intrq_cleared_by_status", INTRQ, 0);

    // Seek and step commands with saturation at both ends
    for (int k = 0; k < 8; k++) begin
      t = (k == 0) ? TRACKS - 1 : (k == 1) ? 0 : $urandom_range(0, TRACKS - 1);
      stepin = (k == 0) ? 1 : (k == 1) ? 0 : 1'($urandom);
      host_wr(2'd3, 8'(t));
      host_wr(2'd0, 8'h10);
      cycles(2);
      host_rd(2'd1, v);  chk("seek_track", v, t);
      host_wr(2'd0, stepin ? 8'h50 : 8'h70);
      cycles(2);
      e = stepin ? ((t + 1 > TRACKS - 1) ? TRACKS - 1 : t + 1) : ((t - 1 < 0) ? 0 : t - 1);
      host_rd(2'd1, v);  chk("step_track", v, e);
    end

    xfer_read(1, 1, 5, 3, 0, SB);
    host_rd(2'd0, v);  chk("read_done_status", v, 8'h00);

    p = wr_pulses;
    xfer_write(2, 0, 10, 16, SB, 1);
    chk("write_pulse_count", wr_pulses - p, SB);
    host_rd(2'd0, v);  chk("write_done_status", v, 8'h00);
    xfer_read(2, 0, 10, 16, 0, SB);

    xfer_read(0, 0, 39, 15, 1, 2 * SB);
    host_rd(2'd0, v);  chk("multi_rnf_status", v, 8'h10);
    host_rd(2'd2, v);  chk("multi_last_sector", v, SECTORS);

    start_cmd(0, 0, 3, 0, 8'h80);
    cycles(1);
    chk("sector0_no_drq", DRQ, 0);
    cycles(2);
    chk("sector0_intrq", INTRQ, 1);
    host_rd(2'd0, v);  chk("sector0_status", v, 8'h10);
    host_wr(2'd0, 8'h00);
    cycles(2);
    host_rd(2'd0, v);  chk("rnf_cleared", v, 8'h00);
    start_cmd(0, 0, TRACKS, 1, 8'h80);
    cycles(3);
    host_rd(2'd0, v);  chk("track40_status", v, 8'h10);

    WPROT = 4'b0100;
    p = wr_pulses;
    start_cmd(2, 0, 10, 5, 8'hA0);
    cycles(4);
    chk("wprot_intrq", INTRQ, 1);
    chk("wprot_no_drq", DRQ, 0);
    host_rd(2'd0, v);  chk("wprot_status", v, 8'h40);
    chk("wprot_no_mem_we", wr_pulses - p, 0);
    WPROT = 4'b0000;
    host_wr(2'd0, 8'h00);
    cycles(2);
    host_rd(2'd0, v);  chk("wprot_bit_cleared", v, 8'h00);

    p = wr_pulses;
    xfer_write(3, 1, 10, 7, 10, 0);
    cycles(3);
    host_wr(2'd0, 8'hD0);
    cycles(3);
    chk("fi_drq", DRQ, 0);
    chk("fi_intrq", INTRQ, 1);
    host_rd(2'd0, v);  chk("fi_status", v, 8'h00);
    chk("fi_pulse_count", wr_pulses - p, 10);
    host_rd(2'd2, v);  chk("fi_sector_kept", v, 7);
    host_rd(2'd1, v);  chk("fi_track_kept", v, 10);
    xfer_read(3, 1, 10, 7, 0, SB);

    // Randomised transfers, each write read back from storage
    for (int k = 0; k < 5; k++) begin
      int d, s, sc;
      d = $urandom_range(0, DRIVES - 1); s = $urandom_range(0, SIDES - 1);
      t = $urandom_range(0, TRACKS - 1); sc = $urandom_range(1, SECTORS);
      if ($urandom_range(0, 1) == 1) begin
        xfer_write(d, s, t, sc, SB, 0);
        xfer_read(d, s, t, sc, 0, SB);
      end else begin
        xfer_read(d, s, t, sc, 0, SB);
      end
    end

    // Reset in the middle of a read
    begin
      int base; bit ok;
      base = ref_addr(1, 0, 20, 9, 0);
      for (int i = 0; i < 5; i++) exp_rd.push_back(img[base + i]);
      rd_mon_en = 1;
      start_cmd(1, 0, 20, 9, 8'h80);
      for (int i = 0; i < 5; i++) begin
        wait_sig(1, ok);
        if (!ok) break;
        host_rd(2'd3, v);
      end
      rd_mon_en = 0;
      exp_rd.delete();
      p = wr_pulses;
      RESET = 1;
      cycles(2);
      RESET = 0;
      cycles(1);
      host_rd(2'd0, v);  chk("midread_reset_status", v, 8'h80);
      chk("midread_reset_drq", DRQ, 0);
      chk("midread_reset_intrq", INTRQ, 0);
      chk("midread_reset_no_we", wr_pulses - p, 0);
      host_rd(2'd1, v);  chk("midread_reset_track", v, 0);
    end

    chk("write_queue_empty", exp_wr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
